// File: rtl/hidden_weight_fetch.sv
// -----------------------------------------------------------------------------
// hidden_weight_fetch
//
// Streams a burst of consecutive words out of a registered-output weight ROM.
// A burst is requested with a one-cycle start pulse that also carries the first
// ROM address and the word count. Reads are issued one per cycle into a two-stage
// read pipeline. The first stage is the cycle in which the address is presented.
// The second stage is the cycle in which the ROM drives its data. Returned words
// land in a 4-entry FIFO whose head drives a valid/ready stream. A read is only
// issued when the FIFO plus the reads still in the pipeline leave a free slot. As
// a result, returning ROM data always has room and never has to be dropped.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle burst request (ignored unless idle)
//   base_addr  in   first ROM address, sampled with start
//   length     in   word count, sampled with start (0 = empty burst)
//   abort      in   cancels the burst in progress
//   rom_addr   out  ROM read address
//   rom_q      in   ROM data, valid one clock after rom_addr
//   w_data     out  streamed weight word
//   w_valid    out  w_data / w_last valid
//   w_ready    in   consumer accepts the word when high with w_valid
//   w_last     out  final word of the burst
//   busy       out  burst in progress (FETCH or DRAIN)
//   done       out  one-cycle pulse after the final word is accepted
// -----------------------------------------------------------------------------
module hidden_weight_fetch #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic                  w_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   LEN_ZERO = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  // FSM state
  state_e state_q, state_d;

  // Address generation
  logic [ADDR_WIDTH-1:0] rom_addr_q;   // address currently presented to the ROM
  logic [ADDR_WIDTH-1:0] next_addr_q;  // address of the next read to issue
  logic [ADDR_WIDTH:0]   remain_q;     // reads still to issue

  // Two-stage read pipeline: issue stage and ROM-output stage
  logic iss_v_q, iss_last_q;
  logic rom_v_q, rom_last_q;

  // 4-entry output FIFO
  logic [DATA_WIDTH-1:0] fifo_data_q [4];
  logic                  fifo_last_q [4];
  logic [1:0]            wr_ptr_q, rd_ptr_q;
  logic [2:0]            count_q;

  // Registered status outputs
  logic busy_q, busy_d;
  logic done_q, done_d;

  // Decoded control
  logic                  start_s;
  logic                  abort_s;
  logic [2:0]            pending_s;
  logic                  room_s;
  logic                  issue_s;
  logic [ADDR_WIDTH-1:0] issue_addr_s;
  logic                  issue_last_s;
  logic                  head_valid_s;
  logic                  head_last_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  final_xfer_s;

  // Request decode, read-issue decision and FIFO handshake
  always_comb begin
    start_s      = start && (state_q == S_IDLE);
    abort_s      = abort && (state_q != S_IDLE);
    // Words buffered plus reads whose data has not landed yet
    pending_s    = count_q + {2'b00, iss_v_q} + {2'b00, rom_v_q};
    room_s       = (pending_s < 3'd4);
    head_valid_s = (count_q != 3'd0);
    head_last_s  = fifo_last_q[rd_ptr_q];
    pop_s        = head_valid_s && w_ready && !abort_s;
    final_xfer_s = pop_s && head_last_s;
    push_s       = rom_v_q && !abort_s;
    if (start_s) begin
      // The first read goes out with start acceptance so base_addr is on
      // rom_addr in the very next cycle.
      issue_s      = (length != LEN_ZERO);
      issue_addr_s = base_addr;
      issue_last_s = (length == LEN_ONE);
    end else if (state_q == S_FETCH) begin
      issue_s      = !abort_s && (remain_q != LEN_ZERO) && room_s;
      issue_addr_s = next_addr_q;
      issue_last_s = (remain_q == LEN_ONE);
    end else begin
      issue_s      = 1'b0;
      issue_addr_s = next_addr_q;
      issue_last_s = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_s) begin
          state_d = (length == LEN_ZERO) ? S_DONE : S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (abort_s) begin
          state_d = S_IDLE;
        end else if ((remain_q == LEN_ZERO) || (issue_s && (remain_q == LEN_ONE))) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        // Abort wins over a simultaneous final-word transfer
        if (abort_s) begin
          state_d = S_IDLE;
        end else if (final_xfer_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM outputs, computed from the next state so busy/done are registered
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      S_FETCH: busy_d = 1'b1;
      S_DRAIN: busy_d = 1'b1;
      S_DONE:  done_d = 1'b1;
      default: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  // Status output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Address generator and remaining-read counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr_q  <= {ADDR_WIDTH{1'b0}};
      next_addr_q <= {ADDR_WIDTH{1'b0}};
      remain_q    <= LEN_ZERO;
    end else begin
      if (issue_s) begin
        rom_addr_q  <= issue_addr_s;
        // Natural overflow of the adder gives the modulo-2^ADDR_WIDTH wrap
        next_addr_q <= issue_addr_s + ADDR_ONE;
      end else begin
        rom_addr_q  <= rom_addr_q;
        next_addr_q <= next_addr_q;
      end
      if (start_s) begin
        remain_q <= (length == LEN_ZERO) ? LEN_ZERO : (length - LEN_ONE);
      end else if (abort_s) begin
        remain_q <= LEN_ZERO;
      end else if (issue_s) begin
        remain_q <= remain_q - LEN_ONE;
      end else begin
        remain_q <= remain_q;
      end
    end
  end

  // Read pipeline: issue stage then ROM-output stage; abort discards both
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_v_q    <= 1'b0;
      iss_last_q <= 1'b0;
      rom_v_q    <= 1'b0;
      rom_last_q <= 1'b0;
    end else if (abort_s) begin
      iss_v_q    <= 1'b0;
      iss_last_q <= 1'b0;
      rom_v_q    <= 1'b0;
      rom_last_q <= 1'b0;
    end else begin
      iss_v_q    <= issue_s;
      iss_last_q <= issue_s && issue_last_s;
      rom_v_q    <= iss_v_q;
      rom_last_q <= iss_last_q;
    end
  end

  // Output FIFO storage and pointers; abort flushes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        fifo_data_q[i] <= {DATA_WIDTH{1'b0}};
        fifo_last_q[i] <= 1'b0;
      end
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else if (abort_s) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      if (push_s) begin
        fifo_data_q[wr_ptr_q] <= rom_q;
        fifo_last_q[wr_ptr_q] <= rom_last_q;
        wr_ptr_q              <= wr_ptr_q + 2'd1;
      end else begin
        wr_ptr_q <= wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end else begin
        rd_ptr_q <= rd_ptr_q;
      end
      count_q <= count_q + {2'b00, push_s} - {2'b00, pop_s};
    end
  end

  // Stream outputs come straight from the FIFO head registers; they are zeroed
  // when empty so no stale word is visible.
  always_comb begin
    w_valid = head_valid_s;
    if (head_valid_s) begin
      w_data = fifo_data_q[rd_ptr_q];
      w_last = head_last_s;
    end else begin
      w_data = {DATA_WIDTH{1'b0}};
      w_last = 1'b0;
    end
  end

  assign rom_addr = rom_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_hidden_weight_fetch.sv
module tb_hidden_weight_fetch;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [14:0] base_addr;
  logic [15:0] length;
  logic        abort;
  logic [14:0] rom_addr;
  logic [7:0]  rom_q;
  logic [7:0]  w_data;
  logic        w_valid;
  logic        w_ready;
  logic        w_last;
  logic        busy;
  logic        done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] rom_mem [0:32767];

  hidden_weight_fetch #(.DATA_WIDTH(8), .ADDR_WIDTH(15)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base_addr(base_addr),
    .length   (length),
    .abort    (abort),
    .rom_addr (rom_addr),
    .rom_q    (rom_q),
    .w_data   (w_data),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .w_last   (w_last),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-output ROM model
  always @(posedge clk) rom_q <= rom_mem[rom_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One burst. mode: 0 ready high, 1 random ready, 2 ready low for 10 cycles.
  // abort_at >= 0 raises abort once that many words have been accepted.
  task automatic burst(input logic [14:0] base, input int len, input int mode, input int abort_at);
    logic [7:0]  exp_d [$];
    logic [14:0] a;
    logic [14:0] diff;
    logic [14:0] stall_addr;
    logic [7:0]  pdata;
    logic        plast;
    bit          pstall;
    bit          xfer;
    int          got;
    int          cyc;
    int          issued;
    got    = 0;
    cyc    = 0;
    pstall = 1'b0;
    pdata  = 8'd0;
    plast  = 1'b0;
    stall_addr = 15'd0;
    for (int i = 0; i < len; i++) begin
      a = base + 15'(i);
      exp_d.push_back(rom_mem[a]);
    end
    // cycle N
    base_addr = base;
    length    = 16'(len);
    start     = 1'b1;
    w_ready   = 1'b0;
    tick();
    // cycle N+1: garbage on the sampled inputs must not matter now
    start     = 1'b0;
    base_addr = 15'($urandom);
    length    = 16'($urandom);
    if (len == 0) begin
      check("len0_done", done, 1);
      check("len0_busy", busy, 0);
      check("len0_valid", w_valid, 0);
      tick();
      check("len0_done_once", done, 0);
      check("len0_busy_after", busy, 0);
      check("len0_valid_after", w_valid, 0);
      return;
    end
    check("n1_rom_addr", rom_addr, base);
    check("n1_busy", busy, 1);
    check("n1_valid", w_valid, 0);
    tick();
    // cycle N+2
    a = (len > 1) ? base + 15'd1 : base;
    check("n2_rom_addr", rom_addr, a);
    check("n2_valid", w_valid, 0);
    tick();
    // cycle N+3
    if (len > 2) begin
      a = base + 15'd2;
      check("n3_rom_addr", rom_addr, a);
    end
    check("n3_valid", w_valid, 1);
    while (got < len) begin
      case (mode)
        1:       w_ready = 1'($urandom_range(0, 1));
        2:       w_ready = (cyc >= 10);
        default: w_ready = 1'b1;
      endcase
      // Stray start pulses mid-burst must be ignored
      start = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      diff   = rom_addr - base;
      issued = int'(diff) + 1;
      check("outstanding_le4", ((issued - got) <= 4), 1);
      if (mode == 2 && cyc == 5) stall_addr = rom_addr;
      if (mode == 2 && cyc == 9) begin
        check("stall_rom_addr_hold", rom_addr, stall_addr);
        check("stall_outstanding", issued - got, 4);
      end
      if (mode == 0) check("sustain_valid", w_valid, 1);
      if (pstall) begin
        check("stall_valid_stable", w_valid, 1);
        check("stall_data_stable", w_data, pdata);
        check("stall_last_stable", w_last, plast);
      end
      if (w_valid) begin
        check("word_data", w_data, exp_d[got]);
        check("word_last", w_last, (got == len - 1));
      end
      check("busy_in_burst", busy, 1);
      check("no_early_done", done, 0);
      pstall = w_valid && !w_ready;
      pdata  = w_data;
      plast  = w_last;
      if (abort_at >= 0 && got == abort_at) begin
        abort   = 1'b1;
        w_ready = 1'b1;
      end
      xfer = w_valid && w_ready;
      tick();
      start = 1'b0;
      if (abort) begin
        abort = 1'b0;
        for (int k = 0; k < 6; k++) begin
          check("abort_busy", busy, 0);
          check("abort_valid", w_valid, 0);
          check("abort_no_done", done, 0);
          tick();
        end
        return;
      end
      if (xfer) got++;
      cyc++;
      if (cyc > 300) begin
        check("burst_timeout", cyc, 300);
        return;
      end
    end
    w_ready = 1'b0;
    check("done_pulse", done, 1);
    check("done_busy_low", busy, 0);
    check("done_valid_low", w_valid, 0);
    tick();
    check("done_once", done, 0);
    check("idle_busy_low", busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) rom_mem[i] = 8'($urandom);
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = 15'd0;
    length    = 16'd0;
    abort     = 1'b0;
    w_ready   = 1'b0;
    repeat (3) tick();
    check("rst_rom_addr", rom_addr, 0);
    check("rst_w_data", w_data, 0);
    check("rst_w_valid", w_valid, 0);
    check("rst_w_last", w_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    tick();

    // Basic burst, back-to-back stream
    burst(15'h0010, 4, 0, -1);
    // Address wrap
    burst(15'h7FFE, 3, 0, -1);
    // Random backpressure
    burst(15'($urandom), 8, 1, -1);
    for (int r = 0; r < 4; r++) burst(15'($urandom), $urandom_range(1, 12), 1, -1);
    // Long stall with full buffering
    burst(15'($urandom), 8, 2, -1);
    // Empty burst
    burst(15'($urandom), 0, 0, -1);
    // Abort after two of six words
    burst(15'($urandom), 6, 0, 2);
    // Abort colliding with the final-word transfer
    burst(15'($urandom), 3, 0, 2);
    // Single-word burst
    burst(15'($urandom), 1, 1, -1);

    // Reset in the middle of a burst
    base_addr = 15'($urandom);
    length    = 16'd6;
    start     = 1'b1;
    w_ready   = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_valid", w_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_rom_addr", rom_addr, 0);
    tick();
    rst_n = 1'b1;
    burst(15'($urandom), 2, 0, -1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hidden_weight_fetch.md
HIDDEN_WEIGHT_FETCH -- requirements
Module: hidden_weight_fetch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning ROM word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 15, meaning ROM address width in bits.
REQ-003 SHALL have a single clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, one-cycle request to begin a burst.
REQ-007 SHALL have port base_addr, input, ADDR_WIDTH, first ROM address, sampled with start.
REQ-008 SHALL have port length, input, ADDR_WIDTH+1, word count, sampled with start.
REQ-009 SHALL have port abort, input, 1, cancels the burst in progress.
REQ-010 SHALL have port rom_addr, output, ADDR_WIDTH, address to the registered-output weight ROM.
REQ-011 SHALL have port rom_q, input, DATA_WIDTH, ROM data, valid one clk after rom_addr.
REQ-012 SHALL have port w_data, output, DATA_WIDTH, streamed weight word.
REQ-013 SHALL have port w_valid, output, 1, w_data/w_last valid.
REQ-014 SHALL have port w_ready, input, 1, consumer accepts the word when high with w_valid.
REQ-015 SHALL have port w_last, output, 1, marks the final word of the burst.
REQ-016 SHALL have port busy, output, 1, high from start acceptance until done or abort.
REQ-017 SHALL have port done, output, 1, one-cycle pulse after the last word is accepted.

Function
REQ-018 SHALL use states IDLE, FETCH, DRAIN, DONE.
REQ-019 SHALL transition IDLE->FETCH on start with length>0, and IDLE->DONE on start with length==0.
REQ-020 SHALL ignore start while not in IDLE.
REQ-021 SHALL, in FETCH, issue one read per cycle (drive rom_addr, mark in-flight) only when FIFO occupancy plus in-flight reads < 4.
REQ-022 SHALL model two in-flight stages: address-issue cycle and ROM-output cycle; rom_q is written into a 4-entry FIFO the cycle after rom_addr is presented.
REQ-023 SHALL increment the address after each issued read, wrapping modulo 2^ADDR_WIDTH (e.g. 0x7FFF -> 0x0000).
REQ-024 SHALL transition FETCH->DRAIN when all length reads are issued.
REQ-025 SHALL transition DRAIN->DONE in the cycle the final word transfers (w_valid&&w_ready&&w_last).
REQ-026 SHALL assert done for exactly one cycle in DONE and then return to IDLE.
REQ-027 SHALL drive w_data/w_valid/w_last from the FIFO head; a word leaves only on w_valid&&w_ready.
REQ-028 SHALL keep w_data, w_last, and w_valid stable while w_valid=1 and w_ready=0.
REQ-029 SHALL assert w_last with only the length-th word of the burst.
REQ-030 SHALL, if start is high in cycle N, drive rom_addr=base_addr in cycle N+1, present the word on rom_q in cycle N+2, and assert w_valid in cycle N+3.
REQ-031 SHALL sustain one word per cycle when w_ready is held high.
REQ-032 SHALL never overflow the FIFO; ROM data arriving for an issued read is always written.
REQ-033 SHALL, on abort in any non-IDLE state, go to IDLE next cycle, flush the FIFO, discard in-flight data, deassert w_valid and busy, and not pulse done.
REQ-034 SHALL give abort priority over a simultaneous final-word transfer: no done pulse.
REQ-035 SHALL make busy high in FETCH and DRAIN, and low in IDLE and DONE.

Reset
REQ-036 SHALL, on rst_n low, asynchronously force state=IDLE, rom_addr=0, w_data=0, w_valid=0, w_last=0, busy=0, done=0, FIFO empty, and in-flight count 0.
REQ-037 SHALL, on reset mid-burst, drop all pending words, and SHALL accept start on the first rising edge after rst_n rises.

Verification
REQ-038 SHALL cover: start with base=0x0010, len=4, w_ready=1 -> words ROM[0x10..0x13] on consecutive cycles from N+3, w_last on the 4th, done pulse next cycle.
REQ-039 SHALL cover: base=0x7FFE, len=3 -> addresses 0x7FFE, 0x7FFF, 0x0000 in order.
REQ-040 SHALL cover: len=8, w_ready toggled randomly -> all 8 words in order, no loss or duplication, and data stable while stalled.
REQ-041 SHALL cover: w_ready=0 for 10 cycles -> at most 4 words buffered, rom_addr issue stalls, and the stream resumes intact.
REQ-042 SHALL cover: len=0 -> no w_valid, busy never high, done one cycle after start.
REQ-043 SHALL cover: abort after 2 of 6 words, then rst_n pulse mid-burst -> IDLE, w_valid=0, no done, and a subsequent len=2 burst is correct.
